// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit path.
// FSM state encodings, byte width and the idle-line byte value.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [UART_DATA_W-1:0] UART_IDLE_BYTE = 8'hFF;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACK  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Scans i_req starting at i_ptr with wrap-around and returns the first set index.
// Shared by other arbiters, so it carries no UART-specific logic.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  int w_pos;

  // Walk N_REQ positions from the pointer; the first requester seen wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers.
// One byte is in flight at a time; a grant waits for the transmitter to
// acknowledge (tx_ready low) and finish (tx_ready high) before re-arbitrating.
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rotating pointer); undefined gives round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*UART_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_ready,
  output logic [IDX_W-1:0]             owner,
  output logic                         busy
);

  logic [1:0]             r_state;
  logic [N_REQ-1:0]       r_gnt;
  logic                   r_txStart;
  logic [UART_DATA_W-1:0] r_txData;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_busy;

  logic [IDX_W-1:0]       w_ptr;
  logic [IDX_W-1:0]       w_pickIdx;
  logic                   w_pickFound;
  logic                   w_grant;
  logic [IDX_W-1:0]       w_nextPtr;
  logic [N_REQ-1:0]       w_gntOneHot;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (w_ptr),
    .o_idx   (w_pickIdx),
    .o_found (w_pickFound)
  );

  assign w_grant     = (r_state == IDLE) && w_pickFound && tx_ready;
  assign w_nextPtr   = (w_pickIdx == IDX_W'(N_REQ - 1)) ? '0 : w_pickIdx + 1'b1;
  assign w_gntOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pickIdx;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // Rotate the search start to just past the requester that was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_nextPtr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Handshake FSM: grant in IDLE, wait for tx_ready to drop, then to rise again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_txStart <= 1'b0;
      r_txData  <= UART_IDLE_BYTE;
      r_owner   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_gnt     <= '0;
      r_txStart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= ACK;
            r_gnt     <= w_gntOneHot;
            r_txStart <= 1'b1;
            r_txData  <= req_data[UART_DATA_W*int'(w_pickIdx) +: UART_DATA_W];
            r_owner   <= w_pickIdx;
            r_busy    <= 1'b1;
          end
        end
        ACK: begin
          if (!tx_ready) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (tx_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign tx_start = r_txStart;
  assign tx_data  = r_txData;
  assign owner    = r_owner;
  assign busy     = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `N_REQ` byte producers (display echo, status reporter, host responder, …). Each requester presents a byte and a request. The arbiter grants requesters in round-robin order, hands the byte to the transmitter with a one-cycle start pulse, and waits for the frame to finish before arbitrating again. It sits between the producer logic and the single `uart_send`-style transmitter that drives the TX pin.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, 2: index width, must equal ceil(log2(`N_REQ`)).
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input `N_REQ`: bit i high means requester i has a byte pending.
- `req_data` input `N_REQ`*8: byte of requester i at bits [8i+7:8i].
- `gnt` output `N_REQ`: one-hot, one-cycle pulse; byte of requester i accepted.
- `tx_start` output 1: one-cycle pulse to the transmitter.
- `tx_data` output 8: byte to the transmitter; valid while `tx_start`=1, then held.
- `tx_ready` input 1: transmitter idle and able to accept a byte.
- `owner` output `IDX_W`: index of the last or current granted requester.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: no transfer in progress.
  - ACK: waiting for `tx_ready` to drop.
  - DONE: waiting for `tx_ready` to rise.
- Transitions:
  - IDLE -> ACK when `|req` and `tx_ready`=1.
  - ACK -> DONE when `tx_ready`=0.
  - DONE -> IDLE when `tx_ready`=1.
- Arbitration (combinational, evaluated only in IDLE): search from pointer `ptr` upward with wrap-around. The first i with `req[i]`=1 wins.
- On the IDLE->ACK edge:
  - `gnt[i]`<=1, `tx_start`<=1, `tx_data`<=`req_data[i]`, `owner`<=i.
  - `ptr`<=i+1 (wraps to 0 when i=`N_REQ`-1).
- Requester contract:
  - Hold `req[i]` and its byte stable until `gnt[i]` is seen.
  - Drop `req[i]` or present the next byte the cycle after `gnt[i]`.
  - A `req` bit that drops before grant is simply not serviced. No error is raised.
- Only one byte is in flight. `req` changes during ACK/DONE are ignored until IDLE.
- If `tx_ready`=0 in IDLE (transmitter busy from elsewhere or still settling), no grant is issued.
- Reset mid-transfer: state goes to IDLE and outputs return to reset values. The transmitter's own reset handles any frame already on the line.
- Reset values: `gnt`=0, `tx_start`=0, `tx_data`=8'hFF, `owner`=0, `busy`=0, `ptr`=0, state IDLE.

## Timing
- Grant latency: one clock edge from IDLE with `req`&`tx_ready` to `gnt`/`tx_start` high.
- `gnt` and `tx_start` are both registered and always coincide.
- `busy` is registered and rises together with `tx_start`.
- The transmitter must drop `tx_ready` within a few cycles of `tx_start`. ACK waits indefinitely; there is no timeout.
- Back-to-back: the earliest next grant is 1 cycle after DONE->IDLE. Minimum gap between `tx_start` pulses is frame length + 2 cycles.
- Simultaneous requests: granted strictly in rotation. With all `N_REQ` requesting continuously, each gets one byte every `N_REQ` frames.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest index always wins, the search starts at 0, and `ptr` is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants: IDLE=2'b00, ACK=2'b01, DONE=2'b10.
  - byte width constant `UART_DATA_W`=8.
  - idle-line value `UART_IDLE_BYTE`=8'hFF.
- One natural sub-module, `rr_pick`: combinational, takes `req` and `ptr`, returns winner index and a found flag. It is reused by other arbiters in the design.

## Test plan
- **Reset:** assert `rst` mid-DONE -> all outputs at reset values within the same cycle; IDLE after release; `tx_data`=8'hFF.
- **Single requester:** `req`=4'b0100, byte 8'h41, `tx_ready`=1 -> next edge `gnt`=4'b0100, `tx_start`=1, `tx_data`=8'h41, `owner`=2.
- **All requesting:** bytes 8'h30..8'h33, transmitter model 20-cycle frames -> `tx_data` order 30,31,32,33,30.
- **Transmitter busy:** `tx_ready`=0 in IDLE with `req`=4'b0001 -> no `gnt` until `tx_ready` rises, then grant on the next edge.
- **Pointer wrap:** grant requester 3, then `req`=4'b1001 -> requester 0 wins next.
- **Fixed-priority build:** same stimulus as "All requesting" with the macro defined -> `tx_data` order 30,30,30…, requester 0 only, while it keeps requesting.
